keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the board's 4x4 keypad, the input-side counterpart of the multiplexed seven-segment display driver. It drives one keypad column low at a time, with the same active-low one-hot select pattern the display uses for its digit enables, and reads the four row lines. Each accepted press is debounced and reported as a 4-bit key code with a one-cycle strobe. It sits between the keypad pins and the control logic that consumes key events.

## Interface
- DIV_BITS, default 16: column dwell period P = 2^DIV_BITS clock cycles.
- DEBOUNCE_N, default 4: number of consecutive confirming samples required for press and for release (range 1..15).

- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
- row_n  input  4  keypad rows, active-low (board pull-ups), asynchronous to clk.
- col_ctl  output  4  column drive, active-low one-hot: 4'b1110 = col0, 4'b1101 = col1, 4'b1011 = col2, 4'b0111 = col3.
- key_code  output  4  last accepted key, {row[1:0], col[1:0]} = row*4+col.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_down  output  1  high from acceptance until debounced release.

## Operation
- Reset values: col_ctl=4'b1110, key_code=0, key_valid=0, key_down=0, FSM=SCAN, divider=0, debounce counter=0, synchronizer flops=4'b1111.
- Synchronization: row_n passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Divider: a free-running DIV_BITS-bit counter, never frozen. The sample point is the cycle where divider == P-1. Rows are evaluated only at sample points.
- State SCAN:
  - At a sample point with rs == 4'b1111, advance the column: col0→1→2→3→0.
  - At a sample point with any rs bit low:
    - Latch the candidate row as the lowest-index low bit; lower rows take priority.
    - Latch the candidate column as the current column.
    - Clear the counter and go to DEBOUNCE. The column does not advance.
- State DEBOUNCE (column frozen on candidate):
  - At each sample point where the candidate row bit is low, increment the counter.
  - When the count reaches DEBOUNCE_N:
    - key_code ← candidate.
    - Pulse key_valid for one cycle.
    - key_down ← 1.
    - Clear the counter and go to HELD.
  - If the candidate row bit is high at a sample point, go to SCAN and advance the column. There is no key_valid and key_code is unchanged.
- State HELD (column frozen):
  - At each sample point where the candidate row bit is high, increment the counter. At a sample point where it is low, clear the counter.
  - When the count reaches DEBOUNCE_N: key_down ← 0, go to SCAN, advance the column.
- Other keys: other rows and other columns are ignored while in DEBOUNCE or HELD. One key is tracked at a time.
- key_code: holds its value until the next acceptance.
- Reset mid-operation: all state returns to reset values immediately. No key_valid is emitted and key_down drops.

## Timing
- Column switching: col_ctl changes in the cycle after a sample point, so every column is driven for exactly P cycles while scanning.
- Press latency: a press stable on row_n is visible in rs 2 cycles later. It becomes a candidate at the next sample point on its column.
  - key_valid is high in the cycle after the DEBOUNCE_N-th confirming sample.
  - Minimum latency from candidate sample to key_valid: DEBOUNCE_N·P + 1 cycles.
- key_down: rises in the same cycle as key_valid. It falls in the cycle after the DEBOUNCE_N-th consecutive high sample.
- key_valid never lasts more than 1 cycle. Two pulses are separated by at least 2·DEBOUNCE_N·P cycles.
- Counters: the debounce counter is 4 bits and saturates at DEBOUNCE_N. The divider wraps modulo 2^DIV_BITS.

## Test plan
All scenarios use DIV_BITS=2 (P=4) and DEBOUNCE_N=3.

- Reset/idle: hold rst low, then release with row_n=4'b1111.
  - During reset: col_ctl=4'b1110, key_valid=0, key_code=0, key_down=0.
  - After release, col_ctl cycles 1110→1101→1011→0111→1110, each held 4 cycles.
- Clean press: drive row_n=4'b1011 (row 2) only while col_ctl=4'b1101 (col1), and hold it.
  - Exactly one key_valid pulse with key_code=4'd9, and key_down=1.
  - col_ctl stays 4'b1101 while the key is held.
- Release: from the held state, drive row_n=4'b1111.
  - key_down falls 12-13 cycles later (3 sample points).
  - Scanning resumes at col_ctl=4'b1011.
  - No key_valid on release.
- Bounce: row 0 low for one sample on col3, then high.
  - No key_valid and key_code unchanged.
  - col_ctl advances to 4'b1110.
  - A second bounce: low for 2 samples, high on the 3rd. Again no key_valid.
- Multi-key priority: rows 1 and 3 low together on col2.
  - key_code=4'd6 (row 1).
  - Pressing col0 row 0 while held produces no new key_valid.
- Reset mid-debounce: assert rst after 2 confirming samples.
  - Outputs return to reset values immediately.
  - No key_valid at any point, including after rst is released.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the debounced key-event outputs.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_ctl;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   modport master (input row_n, output col_ctl, key_code, key_valid, key_down);
   modport slave  (output row_n, input col_ctl, key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time and reports
// debounced presses as a 4-bit code with a one-cycle strobe.
module keypad_scanner #(
   parameter int DIV_BITS   = 16,
   parameter int DEBOUNCE_N = 4
) (
   input logic              clk,
   input logic              rst,
   keypad_scanner_if.master kp
);
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
   state_t state, state_nx;
   logic [3:0] sync1, rs, cnt;
   logic [DIV_BITS-1:0] div;
   logic [1:0] col, cand_row, low_row;
   logic sample, idle_rows, hit, full, latch, advance, accept, rel, cnt_inc, cnt_clr;

   assign sample    = &div;
   assign idle_rows = &rs;
   assign low_row   = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
   assign hit       = !rs[cand_row];
   assign full      = (cnt + 4'd1) == 4'(DEBOUNCE_N);
   assign kp.col_ctl = ~(4'b0001 << col);

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= SCAN;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (sample)
         case (state)
            SCAN:     state_nx = idle_rows ? SCAN : DEBOUNCE;
            DEBOUNCE: state_nx = !hit ? SCAN : full ? HELD : DEBOUNCE;
            HELD:     state_nx = (!hit && full) ? SCAN : HELD;
            default:  state_nx = SCAN;
         endcase
   end

   // hit means "candidate row low": a confirm in DEBOUNCE, a bounce-back in HELD
   always_comb begin
      latch   = sample && state == SCAN && !idle_rows;
      accept  = sample && state == DEBOUNCE && hit && full;
      rel     = sample && state == HELD && !hit && full;
      advance = sample && (state == SCAN ? idle_rows : state == DEBOUNCE ? !hit : rel);
      cnt_inc = sample && !full && (state == DEBOUNCE ? hit : (state == HELD && !hit));
      cnt_clr = latch || accept || rel || (sample && state == HELD && hit);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sync1        <= 4'hF;
         rs           <= 4'hF;
         div          <= '0;
         col          <= '0;
         cand_row     <= '0;
         cnt          <= '0;
         kp.key_code  <= '0;
         kp.key_valid <= 1'b0;
         kp.key_down  <= 1'b0;
      end else begin
         sync1        <= kp.row_n;
         rs           <= sync1;
         div          <= div + DIV_BITS'(1);
         col          <= advance ? col + 2'd1 : col;
         cand_row     <= latch ? low_row : cand_row;
         cnt          <= cnt_clr ? 4'd0 : cnt_inc ? cnt + 4'd1 : cnt;
         kp.key_code  <= accept ? {cand_row, col} : kp.key_code;
         kp.key_valid <= accept;
         kp.key_down  <= accept ? 1'b1 : rel ? 1'b0 : kp.key_down;
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving the scanner, with a key-event
// scoreboard and one task per scenario.
module tb_keypad_scanner;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [15:0] keys = '0;
   int tests = 0;
   int fails = 0;
   int valid_cnt = 0;
   int exp_q[$];
   logic prev_valid = 1'b0;

   keypad_scanner_if kp();
   keypad_scanner #(.DIV_BITS(2), .DEBOUNCE_N(3)) dut (.clk(clk), .rst(rst), .kp(kp));

   always #5 clk = ~clk;

   // a pressed key pulls its row low only while its column is driven low
   always_comb begin
      kp.row_n = 4'hF;
      for (int r = 0; r < 4; r++) kp.row_n[r] = ~|(keys[r*4 +: 4] & ~kp.col_ctl);
   end

   always @(negedge clk) begin
      if (kp.key_valid) begin
         valid_cnt++;
         tests++;
         if (prev_valid) begin
            fails++;
            $display("FAIL valid_width: key_valid high 2 cycles, required 1");
         end
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: key_code=%0d, required no key_valid", kp.key_code);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (kp.key_code !== 4'(e)) begin
               fails++;
               $display("FAIL key_code: got %0d, required %0d", kp.key_code, e);
            end
         end
      end
      prev_valid = kp.key_valid;
   end

   task automatic wait_col(input logic [3:0] c);
      int k;
      for (k = 0; k < 40 && kp.col_ctl !== c; k++) @(negedge clk);
      if (kp.col_ctl !== c) begin
         tests++;
         fails++;
         $display("FAIL wait_col: col_ctl=%b, required %b within 40 cycles", kp.col_ctl, c);
      end
   endtask

   task automatic wait_valid();
      int k;
      for (k = 0; k < 60 && kp.key_valid !== 1'b1; k++) @(negedge clk);
      if (kp.key_valid !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_valid: key_valid=%b, required 1 within 60 cycles", kp.key_valid);
      end
   endtask

   task automatic test_reset();
      logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      repeat (3) @(negedge clk);
      tests++;
      if ({kp.col_ctl, kp.key_code, kp.key_valid, kp.key_down} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_outputs: col=%b code=%0d valid=%b down=%b, required 1110 0 0 0",
                  kp.col_ctl, kp.key_code, kp.key_valid, kp.key_down);
      end
      rst = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tests++;
         if (kp.col_ctl !== seq[i/4]) begin
            fails++;
            $display("FAIL idle_scan cycle %0d: col_ctl=%b, required %b", i, kp.col_ctl, seq[i/4]);
         end
         if (i < 16) @(negedge clk);
      end
   endtask

   task automatic test_clean_press_release();
      int v0, k;
      wait_col(4'b1101);
      keys = 16'(1 << 9);
      exp_q.push_back(9);
      v0 = valid_cnt;
      wait_valid();
      tests++;
      if ({kp.key_down, kp.key_code, kp.col_ctl} !== {1'b1, 4'd9, 4'b1101}) begin
         fails++;
         $display("FAIL press_accept: down=%b code=%0d col=%b, required 1 9 1101",
                  kp.key_down, kp.key_code, kp.col_ctl);
      end
      repeat (20) @(negedge clk);
      tests++;
      if (kp.col_ctl !== 4'b1101 || kp.key_down !== 1'b1 || valid_cnt != v0 + 1) begin
         fails++;
         $display("FAIL press_hold: col=%b down=%b pulses=%0d, required 1101 1 1",
                  kp.col_ctl, kp.key_down, valid_cnt - v0);
      end
      keys = '0;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (kp.key_down === 1'b0) break;
      end
      tests++;
      if (k < 12 || k > 13) begin
         fails++;
         $display("FAIL release_delay: key_down fell after %0d cycles, required 12-13", k);
      end
      tests++;
      if (kp.col_ctl !== 4'b1011 || valid_cnt != v0 + 1 || kp.key_code !== 4'd9) begin
         fails++;
         $display("FAIL release_resume: col=%b pulses=%0d code=%0d, required 1011 1 9",
                  kp.col_ctl, valid_cnt - v0, kp.key_code);
      end
   endtask

   task automatic test_bounce(input int low_samples);
      int v0;
      v0 = valid_cnt;
      wait_col(4'b0111);
      keys = 16'(1 << 3);
      repeat (4 * low_samples) @(negedge clk);
      keys = '0;
      repeat (4) @(negedge clk);
      tests++;
      if (kp.col_ctl !== 4'b1110 || valid_cnt != v0 || kp.key_code !== 4'd9 || kp.key_down !== 1'b0) begin
         fails++;
         $display("FAIL bounce_%0d: col=%b pulses=%0d code=%0d down=%b, required 1110 0 9 0",
                  low_samples, kp.col_ctl, valid_cnt - v0, kp.key_code, kp.key_down);
      end
   endtask

   task automatic test_multi_key();
      int v0, k;
      wait_col(4'b1011);
      keys = 16'((1 << 6) | (1 << 14));
      exp_q.push_back(6);
      v0 = valid_cnt;
      wait_valid();
      keys = keys | 16'd1;
      repeat (24) @(negedge clk);
      tests++;
      if (valid_cnt != v0 + 1 || kp.key_code !== 4'd6 || kp.key_down !== 1'b1 || kp.col_ctl !== 4'b1011) begin
         fails++;
         $display("FAIL multi_key: pulses=%0d code=%0d down=%b col=%b, required 1 6 1 1011",
                  valid_cnt - v0, kp.key_code, kp.key_down, kp.col_ctl);
      end
      keys = '0;
      for (k = 0; k < 20 && kp.key_down !== 1'b0; k++) @(negedge clk);
      tests++;
      if (kp.key_down !== 1'b0) begin
         fails++;
         $display("FAIL multi_release: key_down=%b, required 0 within 20 cycles", kp.key_down);
      end
   endtask

   task automatic test_reset_mid_debounce();
      int v0;
      v0 = valid_cnt;
      wait_col(4'b1110);
      keys = 16'(1 << 4);
      repeat (12) @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if ({kp.col_ctl, kp.key_code, kp.key_valid, kp.key_down} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid: col=%b code=%0d valid=%b down=%b, required 1110 0 0 0",
                  kp.col_ctl, kp.key_code, kp.key_valid, kp.key_down);
      end
      keys = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      tests++;
      if (valid_cnt != v0 || kp.key_code !== 4'd0 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL reset_after: pulses=%0d code=%0d pending=%0d, required 0 0 0",
                  valid_cnt - v0, kp.key_code, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_clean_press_release();
      test_bounce(1);
      test_bounce(2);
      test_multi_key();
      test_reset_mid_debounce();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
